dmem_arbiter: RTL and testbench

- Shares the single data memory (separate read/write ports; word/half/byte addressing) between two requesters: the pipeline MEM stage (CPU) and the debug unit (DBG), which dumps and patches memory over UART.
- One access in flight at a time. CPU has fixed priority, bounded by an anti-starvation counter for DBG.
- Sits between the MEM stage, the debug unit and the memory instance.

---
 rtl/dmem_arbiter_if.sv | 55 +++++
 rtl/dmem_arbiter.sv | 115 +++++++++++
 tb/tb_dmem_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU/DBG requester and memory-port bundle for dmem_arbiter
interface dmem_arbiter_if #(
  parameter int NB_DATA_BUS = 32,
  parameter int NB_ADDRESS  = 10
);
  logic                   i_cpu_req;
  logic                   i_cpu_we;
  logic [NB_ADDRESS-1:0]  i_cpu_addr;
  logic [NB_DATA_BUS-1:0] i_cpu_wdata;
  logic [1:0]             i_cpu_addressing;
  logic                   o_cpu_ack;
  logic [NB_DATA_BUS-1:0] o_cpu_rdata;
  logic                   o_cpu_stall;

  logic                   i_dbg_req;
  logic                   i_dbg_we;
  logic [NB_ADDRESS-1:0]  i_dbg_addr;
  logic [NB_DATA_BUS-1:0] i_dbg_wdata;
  logic [1:0]             i_dbg_addressing;
  logic                   o_dbg_ack;
  logic [NB_DATA_BUS-1:0] o_dbg_rdata;

  logic                   o_mem_r_en;
  logic [NB_ADDRESS-1:0]  o_mem_r_addr;
  logic [1:0]             o_mem_r_addressing;
  logic                   o_mem_w_en;
  logic [NB_ADDRESS-1:0]  o_mem_w_addr;
  logic [NB_DATA_BUS-1:0] o_mem_w_data;
  logic [1:0]             o_mem_w_addressing;
  logic [NB_DATA_BUS-1:0] i_mem_r_data;

  logic                   o_busy;

  modport slave (
    input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata, i_cpu_addressing,
    output o_cpu_ack, o_cpu_rdata, o_cpu_stall,
    input  i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata, i_dbg_addressing,
    output o_dbg_ack, o_dbg_rdata,
    output o_mem_r_en, o_mem_r_addr, o_mem_r_addressing,
    output o_mem_w_en, o_mem_w_addr, o_mem_w_data, o_mem_w_addressing,
    input  i_mem_r_data,
    output o_busy
  );

  modport master (
    output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata, i_cpu_addressing,
    input  o_cpu_ack, o_cpu_rdata, o_cpu_stall,
    output i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata, i_dbg_addressing,
    input  o_dbg_ack, o_dbg_rdata,
    input  o_mem_r_en, o_mem_r_addr, o_mem_r_addressing,
    input  o_mem_w_en, o_mem_w_addr, o_mem_w_data, o_mem_w_addressing,
    output i_mem_r_data,
    input  o_busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-outstanding data-memory arbiter, CPU priority with DBG anti-starvation
module dmem_arbiter #(
  parameter int NB_DATA_BUS  = 32,
  parameter int NB_ADDRESS   = 10,
  parameter int STARVE_LIMIT = 4
) (
  input logic           i_clk,
  input logic           i_reset,
  dmem_arbiter_if.slave bus
);
  localparam int NB_CNT = $clog2(STARVE_LIMIT + 1);
  localparam logic [NB_CNT-1:0] CNT_MAX = NB_CNT'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, WR_ACK, RD_CAPTURE, RD_ACK} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG} owner_t;

  state_t                 state;
  owner_t                 owner;
  logic [NB_CNT-1:0]      starve_cnt;
  logic                   cpu_ack;
  logic                   dbg_ack;
  logic [NB_DATA_BUS-1:0] cpu_rdata;
  logic [NB_DATA_BUS-1:0] dbg_rdata;

  logic                   grant_dbg;
  logic                   grant_cpu;
  logic                   issue;
  logic                   sel_we;
  logic [NB_ADDRESS-1:0]  sel_addr;
  logic [NB_DATA_BUS-1:0] sel_wdata;
  logic [1:0]             sel_addressing;

  // Grant is Mealy on IDLE so the memory sees the access in the same cycle.
  assign grant_dbg = (state == IDLE) & ~i_reset & bus.i_dbg_req
                   & (~bus.i_cpu_req | (starve_cnt == CNT_MAX));
  assign grant_cpu = (state == IDLE) & ~i_reset & bus.i_cpu_req & ~grant_dbg;
  assign issue     = grant_dbg | grant_cpu;

  assign sel_we         = grant_dbg ? bus.i_dbg_we         : bus.i_cpu_we;
  assign sel_addr       = grant_dbg ? bus.i_dbg_addr       : bus.i_cpu_addr;
  assign sel_wdata      = grant_dbg ? bus.i_dbg_wdata      : bus.i_cpu_wdata;
  assign sel_addressing = grant_dbg ? bus.i_dbg_addressing : bus.i_cpu_addressing;

  assign bus.o_mem_w_en         = issue & sel_we;
  assign bus.o_mem_r_en         = issue & ~sel_we;
  assign bus.o_mem_w_addr       = bus.o_mem_w_en ? sel_addr       : '0;
  assign bus.o_mem_w_data       = bus.o_mem_w_en ? sel_wdata      : '0;
  assign bus.o_mem_w_addressing = bus.o_mem_w_en ? sel_addressing : 2'b00;
  assign bus.o_mem_r_addr       = bus.o_mem_r_en ? sel_addr       : '0;
  assign bus.o_mem_r_addressing = bus.o_mem_r_en ? sel_addressing : 2'b00;

  assign bus.o_cpu_ack   = cpu_ack;
  assign bus.o_dbg_ack   = dbg_ack;
  assign bus.o_cpu_rdata = cpu_rdata;
  assign bus.o_dbg_rdata = dbg_rdata;
  assign bus.o_cpu_stall = bus.i_cpu_req & ~cpu_ack;
  assign bus.o_busy      = (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      starve_cnt <= '0;
      cpu_ack    <= 1'b0;
      dbg_ack    <= 1'b0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
    end else begin
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dbg) begin
            owner      <= OWN_DBG;
            starve_cnt <= '0;
          end else if (grant_cpu) begin
            owner <= OWN_CPU;
            // CPU only wins while below the limit, so the increment cannot overflow.
            starve_cnt <= bus.i_dbg_req ? starve_cnt + NB_CNT'(1) : '0;
          end else begin
            starve_cnt <= '0;
          end
          if (issue) begin
            if (sel_we) begin
              state   <= WR_ACK;
              cpu_ack <= grant_cpu;
              dbg_ack <= grant_dbg;
            end else begin
              state <= RD_CAPTURE;
            end
          end
        end
        WR_ACK: begin
          state <= IDLE;
        end
        RD_CAPTURE: begin
          if (owner == OWN_DBG) begin
            dbg_rdata <= bus.i_mem_r_data;
            dbg_ack   <= 1'b1;
          end else if (owner == OWN_CPU) begin
            cpu_rdata <= bus.i_mem_r_data;
            cpu_ack   <= 1'b1;
          end
          state <= RD_ACK;
        end
        RD_ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed bench for dmem_arbiter with a transaction-timing reference model
module tb_dmem_arbiter;
  localparam int NB_DATA_BUS  = 32;
  localparam int NB_ADDRESS   = 10;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.NB_DATA_BUS(NB_DATA_BUS), .NB_ADDRESS(NB_ADDRESS)) bus ();

  dmem_arbiter #(
    .NB_DATA_BUS (NB_DATA_BUS),
    .NB_ADDRESS  (NB_ADDRESS),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Memory the DUT talks to; returns junk when not read so capture timing matters.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (bus.o_mem_w_en) mem[bus.o_mem_w_addr] <= bus.o_mem_w_data;
    bus.i_mem_r_data <= bus.o_mem_r_en ? mem[bus.o_mem_r_addr] : 32'hdead_beef;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: transaction timing from the arbitration rules.
  logic [31:0] mmem [0:1023];
  bit          model_valid = 0;
  int          free_at = 0;
  int          starve = 0;
  int          cpu_ack_at = -1, dbg_ack_at = -1;
  bit          cpu_rd_pend = 0, dbg_rd_pend = 0;
  logic [31:0] cpu_rd_val, dbg_rd_val;
  logic [31:0] exp_cpu_rdata = 0, exp_dbg_rdata = 0;
  string       grants = "";
  int          last_wen_cyc = 0, last_ren_cyc = 0, last_cpu_ack_cyc = 0, last_dbg_ack_cyc = 0;

  bit          e_wen, e_ren, e_cack, e_dack, e_busy, gd, gc, m_we;
  logic [9:0]  e_waddr, e_raddr, m_addr;
  logic [31:0] e_wdata, m_wdata;
  logic [1:0]  e_wadr, e_radr, m_adr;

  always @(negedge clk) begin
    e_cack = (cpu_ack_at == cyc);
    e_dack = (dbg_ack_at == cyc);
    if (e_cack && cpu_rd_pend) begin exp_cpu_rdata = cpu_rd_val; cpu_rd_pend = 0; end
    if (e_dack && dbg_rd_pend) begin exp_dbg_rdata = dbg_rd_val; dbg_rd_pend = 0; end
    e_busy = (cyc < free_at);
    e_wen = 0; e_ren = 0; e_waddr = 0; e_raddr = 0; e_wdata = 0; e_wadr = 0; e_radr = 0;
    if (!rst && cyc >= free_at) begin
      gd = bus.i_dbg_req && (!bus.i_cpu_req || starve == STARVE_LIMIT);
      gc = bus.i_cpu_req && !gd;
      if (gd || gc) begin
        m_we    = gd ? bus.i_dbg_we         : bus.i_cpu_we;
        m_addr  = gd ? bus.i_dbg_addr       : bus.i_cpu_addr;
        m_wdata = gd ? bus.i_dbg_wdata      : bus.i_cpu_wdata;
        m_adr   = gd ? bus.i_dbg_addressing : bus.i_cpu_addressing;
        grants  = {grants, gd ? "D" : "C"};
        if (m_we) begin
          e_wen = 1; e_waddr = m_addr; e_wdata = m_wdata; e_wadr = m_adr;
          mmem[m_addr] = m_wdata;
          free_at = cyc + 2;
          if (gd) dbg_ack_at = cyc + 1; else cpu_ack_at = cyc + 1;
        end else begin
          e_ren = 1; e_raddr = m_addr; e_radr = m_adr;
          free_at = cyc + 3;
          if (gd) begin dbg_ack_at = cyc + 2; dbg_rd_val = mmem[m_addr]; dbg_rd_pend = 1; end
          else    begin cpu_ack_at = cyc + 2; cpu_rd_val = mmem[m_addr]; cpu_rd_pend = 1; end
        end
      end
      if (gd || !bus.i_dbg_req) starve = 0;
      else if (gc) starve = starve + 1;
    end

    chk("mem_w_en",          32'(bus.o_mem_w_en),         32'(e_wen));
    chk("mem_r_en",          32'(bus.o_mem_r_en),         32'(e_ren));
    chk("mem_w_addr",        32'(bus.o_mem_w_addr),       32'(e_waddr));
    chk("mem_w_data",        bus.o_mem_w_data,            e_wdata);
    chk("mem_w_addressing",  32'(bus.o_mem_w_addressing), 32'(e_wadr));
    chk("mem_r_addr",        32'(bus.o_mem_r_addr),       32'(e_raddr));
    chk("mem_r_addressing",  32'(bus.o_mem_r_addressing), 32'(e_radr));
    if (model_valid) begin
      chk("cpu_ack",   32'(bus.o_cpu_ack),   32'(e_cack));
      chk("dbg_ack",   32'(bus.o_dbg_ack),   32'(e_dack));
      chk("cpu_rdata", bus.o_cpu_rdata,      exp_cpu_rdata);
      chk("dbg_rdata", bus.o_dbg_rdata,      exp_dbg_rdata);
      chk("busy",      32'(bus.o_busy),      32'(e_busy));
      chk("cpu_stall", 32'(bus.o_cpu_stall), 32'(bus.i_cpu_req & ~e_cack));
    end

    if (bus.o_mem_w_en) last_wen_cyc = cyc;
    if (bus.o_mem_r_en) last_ren_cyc = cyc;
    if (bus.o_cpu_ack)  last_cpu_ack_cyc = cyc;
    if (bus.o_dbg_ack)  last_dbg_ack_cyc = cyc;

    if (rst) begin
      model_valid   = 1;
      free_at       = cyc + 1;
      starve        = 0;
      cpu_ack_at    = -1;
      dbg_ack_at    = -1;
      cpu_rd_pend   = 0;
      dbg_rd_pend   = 0;
      exp_cpu_rdata = 0;
      exp_dbg_rdata = 0;
    end
    cyc++;
  end

  task automatic access(input bit dbg, input bit we, input logic [9:0] addr,
                        input logic [31:0] wd, input logic [1:0] adr);
    int n;
    @(posedge clk); #1;
    if (dbg) begin
      bus.i_dbg_we = we; bus.i_dbg_addr = addr; bus.i_dbg_wdata = wd;
      bus.i_dbg_addressing = adr; bus.i_dbg_req = 1'b1;
    end else begin
      bus.i_cpu_we = we; bus.i_cpu_addr = addr; bus.i_cpu_wdata = wd;
      bus.i_cpu_addressing = adr; bus.i_cpu_req = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dbg ? bus.o_dbg_ack : bus.o_cpu_ack) && n < 50);
    chk(dbg ? "dbg_ack_wait" : "cpu_ack_wait", 32'(dbg ? bus.o_dbg_ack : bus.o_cpu_ack), 32'd1);
    @(posedge clk); #1;
    if (dbg) bus.i_dbg_req = 1'b0; else bus.i_cpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.i_cpu_req = 0; bus.i_cpu_we = 0; bus.i_cpu_addr = 0; bus.i_cpu_wdata = 0; bus.i_cpu_addressing = 0;
    bus.i_dbg_req = 0; bus.i_dbg_we = 0; bus.i_dbg_addr = 0; bus.i_dbg_wdata = 0; bus.i_dbg_addressing = 0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]  = 32'h5a00_0000 | 32'(i);
      mmem[i] = 32'h5a00_0000 | 32'(i);
    end

    // Reset held for two edges, then released.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",      32'(bus.o_busy),    32'd0);
    chk("rst_cpu_rdata", bus.o_cpu_rdata,    32'd0);
    chk("rst_dbg_ack",   32'(bus.o_dbg_ack), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("idle_busy",      32'(bus.o_busy),      32'd0);
    chk("idle_mem_w_en",  32'(bus.o_mem_w_en),  32'd0);
    chk("idle_mem_r_en",  32'(bus.o_mem_r_en),  32'd0);
    chk("idle_cpu_ack",   32'(bus.o_cpu_ack),   32'd0);
    chk("idle_dbg_rdata", bus.o_dbg_rdata,      32'd0);

    // CPU word write then read-back.
    access(0, 1, 10'h000, 32'h0123abcd, 2'b00);
    chk("wr_ack_latency", 32'(last_cpu_ack_cyc - last_wen_cyc), 32'd1);
    access(0, 0, 10'h000, 32'h0, 2'b00);
    chk("rd_ack_latency", 32'(last_cpu_ack_cyc - last_ren_cyc), 32'd2);
    chk("cpu_rd_value", bus.o_cpu_rdata, 32'h0123abcd);
    repeat (3) @(negedge clk);
    chk("cpu_rd_held", bus.o_cpu_rdata, 32'h0123abcd);

    // DBG byte read of the same word; CPU data must stay put.
    access(1, 0, 10'h000, 32'h0, 2'b11);
    chk("dbg_rd_latency", 32'(last_dbg_ack_cyc - last_ren_cyc), 32'd2);
    chk("dbg_rd_value",   bus.o_dbg_rdata, 32'h0123abcd);
    chk("cpu_rd_keep",    bus.o_cpu_rdata, 32'h0123abcd);

    // Same-cycle writes with counter at 0: CPU first, DBG after an IDLE cycle.
    grants = "";
    fork
      access(0, 1, 10'h020, 32'h1111_2222, 2'b00);
      access(1, 1, 10'h021, 32'h3333_4444, 2'b01);
    join
    chk("tie_order",   32'(grants == "CD"), 32'd1);
    chk("tie_dbg_gap", 32'(last_dbg_ack_cyc - last_cpu_ack_cyc >= 2), 32'd1);
    access(0, 0, 10'h021, 32'h0, 2'b00);
    chk("dbg_wr_landed", bus.o_cpu_rdata, 32'h3333_4444);

    // Both requesting continuously: anti-starvation every fifth grant.
    grants = "";
    @(posedge clk); #1;
    bus.i_cpu_we = 0; bus.i_cpu_addr = 10'h020; bus.i_cpu_addressing = 2'b00; bus.i_cpu_req = 1;
    bus.i_dbg_we = 0; bus.i_dbg_addr = 10'h021; bus.i_dbg_addressing = 2'b00; bus.i_dbg_req = 1;
    repeat (30) @(posedge clk);
    #1;
    bus.i_cpu_req = 0; bus.i_dbg_req = 0;
    repeat (4) @(negedge clk);
    chk("starve_sequence", 32'(grants == "CCCCDCCCCD"), 32'd1);
    chk("starve_cpu_data", bus.o_cpu_rdata, 32'h1111_2222);
    chk("starve_dbg_data", bus.o_dbg_rdata, 32'h3333_4444);

    // Reset during RD_CAPTURE of a CPU read, request held through it.
    @(posedge clk); #1;
    bus.i_cpu_we = 0; bus.i_cpu_addr = 10'h005; bus.i_cpu_addressing = 2'b00; bus.i_cpu_req = 1;
    @(negedge clk);
    chk("abort_issue", 32'(bus.o_mem_r_en), 32'd1);
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("abort_no_ack_capture", 32'(bus.o_cpu_ack), 32'd0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("abort_no_ack_after", 32'(bus.o_cpu_ack), 32'd0);
    chk("abort_rdata_clear",  bus.o_cpu_rdata,    32'd0);
    chk("abort_idle",         32'(bus.o_busy),    32'd0);
    chk("abort_reissue",      32'(bus.o_mem_r_en), 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.o_cpu_ack && n < 50);
    chk("reissue_ack",   32'(bus.o_cpu_ack), 32'd1);
    chk("reissue_rdata", bus.o_cpu_rdata,    32'h5a00_0005);
    @(posedge clk); #1;
    bus.i_cpu_req = 0;

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
